// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// It registers the winner's operands, holds them for the op latency and returns a registered result.
module alu_arbiter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MUL_LAT = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,

   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [WIDTH-1:0] req0_data1_i,
   input  logic [WIDTH-1:0] req0_data2_i,
   input  logic [2:0]       req0_ctrl_i,

   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [WIDTH-1:0] req1_data1_i,
   input  logic [WIDTH-1:0] req1_data2_i,
   input  logic [2:0]       req1_ctrl_i,

   output logic [WIDTH-1:0] alu_data1_o,
   output logic [WIDTH-1:0] alu_data2_o,
   output logic [2:0]       alu_ctrl_o,
   input  logic [WIDTH-1:0] alu_result_i,

   output logic             rsp0_valid_o,
   output logic             rsp1_valid_o,
   output logic [WIDTH-1:0] rsp_data_o,
   output logic             busy_o
);

   localparam logic [2:0] CtrlMul = 3'b011;
   // Multiply holds the operands for MUL_LAT cycles; counter runs MUL_LAT-1 .. 0.
   localparam logic [3:0] MulCnt  = 4'(MUL_LAT - 1);

   typedef enum logic [0:0] {StIdle, StExec} state_e;

   state_e           r_state;
   state_e           w_state_d;
   logic             r_ptr;
   logic             r_owner;
   logic [3:0]       r_cnt;
   logic [WIDTH-1:0] r_alu_data1;
   logic [WIDTH-1:0] r_alu_data2;
   logic [2:0]       r_alu_ctrl;
   logic [WIDTH-1:0] r_rsp_data;
   logic             r_rsp0_valid;
   logic             r_rsp1_valid;

   logic             w_idle;
   logic             w_ready0;
   logic             w_ready1;
   logic             w_accept;
   logic             w_done;
   logic [WIDTH-1:0] w_sel_data1;
   logic [WIDTH-1:0] w_sel_data2;
   logic [2:0]       w_sel_ctrl;

   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle:  if (w_accept) w_state_d = StExec;
         StExec:  if (r_cnt == 4'd0) w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // Output logic: ready favours ptr only under contention
   always_comb begin
      w_idle   = (r_state == StIdle);
      w_ready0 = w_idle & req0_valid_i & (~r_ptr | ~req1_valid_i);
      w_ready1 = w_idle & req1_valid_i & (r_ptr | ~req0_valid_i);
      busy_o   = (r_state == StExec);
   end

   assign w_accept = w_ready0 | w_ready1;
   assign w_done   = (r_state == StExec) && (r_cnt == 4'd0);

   assign w_sel_data1 = w_ready1 ? req1_data1_i : req0_data1_i;
   assign w_sel_data2 = w_ready1 ? req1_data2_i : req0_data2_i;
   assign w_sel_ctrl  = w_ready1 ? req1_ctrl_i  : req0_ctrl_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_alu_data1 <= '0;
         r_alu_data2 <= '0;
         r_alu_ctrl  <= 3'b000;
         r_owner     <= 1'b0;
      end else if (w_accept) begin
         r_alu_data1 <= w_sel_data1;
         r_alu_data2 <= w_sel_data2;
         r_alu_ctrl  <= w_sel_ctrl;
         r_owner     <= w_ready1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_cnt <= 4'd0;
      end else if (w_accept) begin
         r_cnt <= (w_sel_ctrl == CtrlMul) ? MulCnt : 4'd0;
      end else if ((r_state == StExec) && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Completion: capture result, pulse owner's response, hand priority to the other side
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_rsp_data   <= '0;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         r_ptr        <= 1'b0;
      end else begin
         r_rsp0_valid <= w_done & ~r_owner;
         r_rsp1_valid <= w_done & r_owner;
         if (w_done) begin
            r_rsp_data <= alu_result_i;
            r_ptr      <= ~r_owner;
         end
      end
   end

   assign req0_ready_o = w_ready0;
   assign req1_ready_o = w_ready1;
   assign alu_data1_o  = r_alu_data1;
   assign alu_data2_o  = r_alu_data2;
   assign alu_ctrl_o   = r_alu_ctrl;
   assign rsp_data_o   = r_rsp_data;
   assign rsp0_valid_o = r_rsp0_valid;
   assign rsp1_valid_o = r_rsp1_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and an expected-response scoreboard.
module tb_alu_arbiter;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned MUL_LAT = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid, req0_ready;
   logic [WIDTH-1:0] req0_data1, req0_data2;
   logic [2:0]       req0_ctrl;
   logic             req1_valid, req1_ready;
   logic [WIDTH-1:0] req1_data1, req1_data2;
   logic [2:0]       req1_ctrl;
   logic [WIDTH-1:0] alu_data1, alu_data2, alu_result, rsp_data;
   logic [2:0]       alu_ctrl;
   logic             rsp0_valid, rsp1_valid, busy;

   typedef struct packed {
      logic             owner;
      logic [WIDTH-1:0] data;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
      .clk_i        (clk),
      .rst_i        (rst_n),
      .req0_valid_i (req0_valid),
      .req0_ready_o (req0_ready),
      .req0_data1_i (req0_data1),
      .req0_data2_i (req0_data2),
      .req0_ctrl_i  (req0_ctrl),
      .req1_valid_i (req1_valid),
      .req1_ready_o (req1_ready),
      .req1_data1_i (req1_data1),
      .req1_data2_i (req1_data2),
      .req1_ctrl_i  (req1_ctrl),
      .alu_data1_o  (alu_data1),
      .alu_data2_o  (alu_data2),
      .alu_ctrl_o   (alu_ctrl),
      .alu_result_i (alu_result),
      .rsp0_valid_o (rsp0_valid),
      .rsp1_valid_o (rsp1_valid),
      .rsp_data_o   (rsp_data),
      .busy_o       (busy)
   );

   // External ALU; unknown codes pass data1 through
   function automatic logic [WIDTH-1:0] alu_model(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [2:0]       c);
      case (c)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b011:  return a * b;
         default: return a;
      endcase
   endfunction

   assign alu_result = alu_model(alu_data1, alu_data2, alu_ctrl);

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [WIDTH-1:0] obs,
                           input logic [WIDTH-1:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drv0(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [2:0] c);
      req0_valid = v; req0_data1 = a; req0_data2 = b; req0_ctrl = c;
   endtask

   task automatic drv1(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [2:0] c);
      req1_valid = v; req1_data1 = a; req1_data2 = b; req1_ctrl = c;
   endtask

   task automatic push(input logic owner, input logic [WIDTH-1:0] data);
      sb_q.push_back({owner, data});
   endtask

   // Response monitor: every pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && (rsp0_valid || rsp1_valid)) begin
         chk_bit("rsp_onehot", rsp0_valid & rsp1_valid, 1'b0);
         chk_bit("sb_nonempty", sb_q.size() != 0, 1'b1);
         if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            chk_bit("rsp_owner", rsp1_valid, mon_e.owner);
            chk_word("rsp_data", rsp_data, mon_e.data);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      drv0(1'b0, '0, '0, 3'b000);
      drv1(1'b0, '0, '0, 3'b000);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_word("rst_alu_d1", alu_data1, '0);
      chk_word("rst_alu_d2", alu_data2, '0);
      chk_word("rst_alu_ctrl", WIDTH'(alu_ctrl), '0);
      chk_word("rst_rsp_data", rsp_data, '0);
      chk_bit("rst_rsp0", rsp0_valid, 1'b0);
      chk_bit("rst_rsp1", rsp1_valid, 1'b0);
      chk_bit("rst_busy", busy, 1'b0);

      // Single add
      cyc();
      rst_n = 1'b1;
      drv0(1'b1, 5, 7, 3'b010);
      @(negedge clk);
      chk_bit("add_rdy0", req0_ready, 1'b1);
      chk_bit("add_rdy1", req1_ready, 1'b0);
      chk_bit("add_busy0", busy, 1'b0);
      push(1'b0, 12);
      cyc();
      drv0(1'b0, '0, '0, 3'b000);
      @(negedge clk);
      chk_word("add_alu_d1", alu_data1, 5);
      chk_word("add_alu_d2", alu_data2, 7);
      chk_word("add_alu_ctrl", WIDTH'(alu_ctrl), 2);
      chk_bit("add_busy1", busy, 1'b1);
      chk_bit("add_rsp0_early", rsp0_valid, 1'b0);
      cyc();
      @(negedge clk);
      chk_bit("add_rsp0", rsp0_valid, 1'b1);
      chk_bit("add_busy2", busy, 1'b0);
      cyc();
      @(negedge clk);
      chk_bit("add_rsp0_pulse", rsp0_valid, 1'b0);
      chk_word("add_rsp_hold", rsp_data, 12);

      // Contention from reset: grants alternate 0,1,0,1
      cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      drv0(1'b1, 9, 4, 3'b110);
      drv1(1'b1, 8, 3, 3'b001);
      for (int c = 0; c < 8; c++) begin
         if (c > 0) cyc();
         @(negedge clk);
         chk_bit("cont_rdy0", req0_ready, (c % 4) == 0);
         chk_bit("cont_rdy1", req1_ready, (c % 4) == 2);
         chk_bit("cont_rsp0", rsp0_valid, (c % 4) == 2);
         chk_bit("cont_rsp1", rsp1_valid, (c >= 4) && ((c % 4) == 0));
         if ((c % 4) == 0) push(1'b0, 5);
         if ((c % 4) == 2) push(1'b1, 11);
      end
      cyc();
      drv0(1'b0, '0, '0, 3'b000);
      drv1(1'b0, '0, '0, 3'b000);
      @(negedge clk);
      chk_bit("cont_rsp1_last", rsp1_valid, 1'b1);

      // Single requester 1 with ptr=0: granted every idle cycle
      for (int c = 0; c < 6; c++) begin
         cyc();
         drv1(1'b1, WIDTH'(100 + (c + 1) / 2), 3, 3'b010);
         @(negedge clk);
         chk_bit("single_rdy1", req1_ready, (c % 2) == 0);
         chk_bit("single_rdy0", req0_ready, 1'b0);
         chk_bit("single_busy", busy, (c % 2) == 1);
         chk_bit("single_rsp1", rsp1_valid, (c >= 2) && ((c % 2) == 0));
         if ((c % 2) == 0) push(1'b1, WIDTH'(103 + c / 2));
      end
      cyc();
      drv1(1'b0, '0, '0, 3'b000);
      @(negedge clk);
      chk_bit("single_rsp1_last", rsp1_valid, 1'b1);

      // Multiply holds operands MUL_LAT cycles; req0 waits through EXEC
      cyc();
      drv1(1'b1, 6, 7, 3'b011);
      @(negedge clk);
      chk_bit("mul_rdy1", req1_ready, 1'b1);
      push(1'b1, 42);
      for (int c = 1; c <= 3; c++) begin
         cyc();
         if (c == 1) begin
            drv1(1'b0, '0, '0, 3'b000);
            drv0(1'b1, 1, 2, 3'b010);
         end
         @(negedge clk);
         chk_word("mul_alu_d1", alu_data1, 6);
         chk_word("mul_alu_d2", alu_data2, 7);
         chk_word("mul_alu_ctrl", WIDTH'(alu_ctrl), 3);
         chk_bit("mul_busy", busy, 1'b1);
         chk_bit("mul_rdy0_wait", req0_ready, 1'b0);
         chk_bit("mul_rsp1_early", rsp1_valid, 1'b0);
      end
      cyc();
      @(negedge clk);
      chk_bit("mul_rsp1", rsp1_valid, 1'b1);
      chk_bit("mul_rdy0", req0_ready, 1'b1);
      chk_bit("mul_busy_done", busy, 1'b0);
      push(1'b0, 3);
      cyc();
      drv0(1'b0, '0, '0, 3'b000);
      @(negedge clk);
      chk_word("mul_next_d1", alu_data1, 1);
      cyc();
      @(negedge clk);
      chk_bit("mul_next_rsp0", rsp0_valid, 1'b1);

      // Reset in cycle 2 of a multiply: abandoned, no response
      cyc();
      drv0(1'b1, 3, 5, 3'b011);
      @(negedge clk);
      chk_bit("rmul_rdy0", req0_ready, 1'b1);
      cyc();
      drv0(1'b0, '0, '0, 3'b000);
      @(negedge clk);
      chk_bit("rmul_busy", busy, 1'b1);
      cyc();
      #1 rst_n = 1'b0;
      #1;
      chk_word("rmul_alu_d1", alu_data1, '0);
      chk_word("rmul_alu_d2", alu_data2, '0);
      chk_word("rmul_alu_ctrl", WIDTH'(alu_ctrl), '0);
      chk_word("rmul_rsp_data", rsp_data, '0);
      chk_bit("rmul_busy0", busy, 1'b0);
      cyc();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk_bit("rmul_no_rsp0", rsp0_valid, 1'b0);
         chk_bit("rmul_no_rsp1", rsp1_valid, 1'b0);
         cyc();
      end
      drv0(1'b1, 1, 1, 3'b010);
      drv1(1'b1, 3, 3, 3'b010);
      @(negedge clk);
      chk_bit("rmul_ptr_rdy0", req0_ready, 1'b1);
      chk_bit("rmul_ptr_rdy1", req1_ready, 1'b0);
      push(1'b0, 2);
      cyc();
      drv0(1'b0, '0, '0, 3'b000);
      drv1(1'b0, '0, '0, 3'b000);
      cyc();
      @(negedge clk);
      chk_bit("rmul_ptr_rsp0", rsp0_valid, 1'b1);

      // Undefined ctrl passes straight through with single-cycle latency
      cyc();
      drv1(1'b1, 32'hDEAD0000, 32'h0000_1234, 3'b111);
      @(negedge clk);
      chk_bit("undef_rdy1", req1_ready, 1'b1);
      push(1'b1, 32'hDEAD0000);
      cyc();
      drv1(1'b0, '0, '0, 3'b000);
      @(negedge clk);
      chk_word("undef_alu_ctrl", WIDTH'(alu_ctrl), 7);
      cyc();
      @(negedge clk);
      chk_bit("undef_rsp1", rsp1_valid, 1'b1);
      chk_word("undef_rsp_data", rsp_data, 32'hDEAD0000);
      cyc();
      cyc();
      @(negedge clk);
      chk_bit("undef_rsp1_pulse", rsp1_valid, 1'b0);
      chk_word("undef_rsp_hold", rsp_data, 32'hDEAD0000);

      chk_word("sb_drained", WIDTH'(sb_q.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. the EX stage and a secondary unit.
- Arbitrates round-robin, registers the operands into the ALU, and holds them for the op's latency: 1 cycle, or MUL_LAT cycles for multiply (ALUCtrl 3'b011, a multicycle path).
- Captures the ALU result and returns it to the winning requester with a one-cycle response pulse.

Parameters:
- WIDTH, 32, operand/result width.
- MUL_LAT, 3, cycles the ALU is held for ctrl 3'b011; legal range 1..15.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- req0_valid_i  input  1  requester 0 has an op.
- req0_ready_o  output  1  requester 0 op accepted this cycle.
- req0_data1_i  input  WIDTH  requester 0 operand 1.
- req0_data2_i  input  WIDTH  requester 0 operand 2.
- req0_ctrl_i  input  3  requester 0 ALU control.
- req1_valid_i / req1_ready_o / req1_data1_i / req1_data2_i / req1_ctrl_i: same as requester 0, for requester 1.
- alu_data1_o  output  WIDTH  to ALU data1_i, registered.
- alu_data2_o  output  WIDTH  to ALU data2_i, registered.
- alu_ctrl_o  output  3  to ALU ALUCtrl_i, registered.
- alu_result_i  input  WIDTH  from ALU data_o.
- rsp0_valid_o  output  1  one-cycle pulse: result for requester 0.
- rsp1_valid_o  output  1  one-cycle pulse: result for requester 1.
- rsp_data_o  output  WIDTH  result, registered; valid only when a rsp*_valid_o is high.
- busy_o  output  1  high while state is EXEC.

Behaviour:
- Reset values (async, rst_i low):
  - State IDLE; priority pointer ptr = 0 (requester 0 favoured).
  - Counter cnt = 0.
  - alu_data1_o, alu_data2_o, rsp_data_o = 0; alu_ctrl_o = 3'b000.
  - rsp0_valid_o, rsp1_valid_o, busy_o = 0.
- States: IDLE, EXEC.
- Ready logic, combinational, asserted only in IDLE:
  - req0_ready_o = IDLE & req0_valid_i & (ptr==0 | !req1_valid_i).
  - req1_ready_o = IDLE & req1_valid_i & (ptr==1 | !req0_valid_i).
  - At most one ready is high per cycle.
- Requester rule: hold valid, data and ctrl stable until ready; drop or replace them the cycle after ready.
- IDLE -> EXEC on a clock edge with a ready high:
  - Latch the winner's data1/data2/ctrl into the alu_*_o registers.
  - Record owner = winner.
  - Load cnt = MUL_LAT-1 if ctrl==3'b011, else cnt = 0.
- EXEC:
  - alu_*_o are held constant.
  - If cnt != 0: decrement cnt and stay in EXEC.
  - If cnt == 0:
    - Capture alu_result_i into rsp_data_o.
    - Set rsp<owner>_valid_o = 1 for the next cycle only.
    - Set ptr = !owner.
    - Go to IDLE.
- Timing:
  - Accept in cycle N; ALU operands visible from N+1.
  - Non-multiply: rsp valid in N+2.
  - Multiply: rsp valid in N+1+MUL_LAT.
  - The response cycle is an IDLE cycle, so a new accept may coincide with it. Peak throughput: one op per 2 cycles (non-multiply).
- ctrl codes:
  - 3'b011 is the only multi-cycle op.
  - All other codes, including undefined 100/101/111, are passed through unchanged with single-cycle latency.
- In IDLE, alu_*_o keep the last op's values; ALU output is ignored.
- rsp_data_o holds its value until the next capture.
- Fairness:
  - With both requesters continuously valid, grants strictly alternate.
  - With a single requester, it is granted every IDLE cycle regardless of ptr.
  - ptr updates only on completion.
- A requester valid in EXEC waits; no ready is given and no request is lost.
- Reset mid-EXEC: the op is abandoned with no response pulse; all state returns to reset values.
- Arithmetic is done by the ALU; this block never modifies operands or result (no width change).

Test Plan:
- Add: req0 valid, data1=5, data2=7, ctrl=010 in cycle 0 -> req0_ready_o=1 in cycle 0; alu_*_o=5/7/010 in cycle 1; rsp0_valid_o=1, rsp_data_o=12 in cycle 2; busy_o high in cycle 1 only.
- Contention: both valid continuously from reset, req0 ctrl 110 (9,4), req1 ctrl 001 (8,3) -> grants 0,1,0,1; rsp0 data 5 and rsp1 data 11 alternate every 2 cycles; never both ready.
- Multiply, MUL_LAT=3: req1 ctrl 011, 6 x 7 accepted cycle 0 -> alu_*_o stable cycles 1-3; rsp1_valid_o=1, rsp_data_o=42 in cycle 4; req0 arriving in cycle 1 gets ready in cycle 4.
- Single requester: req1 valid back-to-back with ptr=0 and req0 idle -> req1 accepted every IDLE cycle, one response per 2 cycles.
- Reset mid-multiply: rst_i low in cycle 2 of a multiply -> all outputs 0 asynchronously; no rsp pulse after release; ptr=0.
- Undefined ctrl: ctrl=111, data1=0xDEAD0000 -> response in N+2 with rsp_data_o=0xDEAD0000 (ALU passthrough).
